// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared configuration for the instruction cache and the memory controller:
// default geometry (BLOCK_WIDTH, CACHE_WIDTH, ADDR_WIDTH), derived sizes
// (BLOCK_SIZE, BLOCK_NUM, TAG_WIDTH) and the IDLE/MISS state encoding.
// No ports.
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int BLOCK_WIDTH = 1;   // log2 of instructions per block
  localparam int CACHE_WIDTH = 8;   // log2 of block count (direct-mapped)
  localparam int ADDR_WIDTH  = 32;  // byte-address width

  localparam int BLOCK_SIZE  = 1 << BLOCK_WIDTH;
  localparam int BLOCK_NUM   = 1 << CACHE_WIDTH;
  localparam int TAG_WIDTH   = ADDR_WIDTH - CACHE_WIDTH - BLOCK_WIDTH - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } ic_state_e;

  // Tag width for an arbitrary geometry; the two low byte bits are never stored.
  function automatic int calc_tag_width(input int addr_w, input int cache_w, input int block_w);
    return addr_w - cache_w - block_w - 2;
  endfunction

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Groups the fetch-unit and memory-controller handshakes of the icache.
//   IFIC_en/IFIC_addr     fetch request (fetch unit -> cache)
//   ICIF_en/ICIF_inst     fetch response, one-cycle pulse (cache -> fetch unit)
//   ICMC_en/ICMC_addr     block refill request (cache -> memory controller)
//   MCIC_en/MCIC_block    refill data, one-cycle pulse (controller -> cache)
//   ICIF_hit_cnt/_miss_cnt performance counters (cache -> observers)
// Modports: slave = the cache side, master = the surrounding system.
// -----------------------------------------------------------------------------
interface icache_if #(
  parameter int ADDR_WIDTH  = icache_pkg::ADDR_WIDTH,
  parameter int BLOCK_WIDTH = icache_pkg::BLOCK_WIDTH
);

  localparam int BLOCK_BITS = 32 << BLOCK_WIDTH;

  logic                  IFIC_en;
  logic [ADDR_WIDTH-1:0] IFIC_addr;
  logic                  ICIF_en;
  logic [31:0]           ICIF_inst;
  logic                  ICMC_en;
  logic [ADDR_WIDTH-1:0] ICMC_addr;
  logic                  MCIC_en;
  logic [BLOCK_BITS-1:0] MCIC_block;
  logic [31:0]           ICIF_hit_cnt;
  logic [31:0]           ICIF_miss_cnt;

  modport slave (
    input  IFIC_en, IFIC_addr, MCIC_en, MCIC_block,
    output ICIF_en, ICIF_inst, ICMC_en, ICMC_addr, ICIF_hit_cnt, ICIF_miss_cnt
  );

  modport master (
    output IFIC_en, IFIC_addr, MCIC_en, MCIC_block,
    input  ICIF_en, ICIF_inst, ICMC_en, ICMC_addr, ICIF_hit_cnt, ICIF_miss_cnt
  );

endinterface

// File: rtl/icache_tag_array.sv
// -----------------------------------------------------------------------------
// icache_tag_array
// Valid bits and tags of the direct-mapped icache, with the hit compare.
//   clk, rst_n     clock, asynchronous active-low reset (clears valid bits)
//   rd_index_i     line selected by the current lookup
//   rd_tag_i       tag of the current lookup
//   hit_o          line is valid and its tag matches (combinational)
//   wr_en_i        install a line (refill completion)
//   wr_index_i     line being installed
//   wr_tag_i       tag being installed
// -----------------------------------------------------------------------------
module icache_tag_array #(
  parameter int CACHE_WIDTH = icache_pkg::CACHE_WIDTH,
  parameter int TAG_WIDTH   = icache_pkg::TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CACHE_WIDTH-1:0] rd_index_i,
  input  logic [TAG_WIDTH-1:0]   rd_tag_i,
  output logic                   hit_o,
  input  logic                   wr_en_i,
  input  logic [CACHE_WIDTH-1:0] wr_index_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i
);

  localparam int BLOCK_NUM = 1 << CACHE_WIDTH;

  logic [BLOCK_NUM-1:0] valid_q;
  logic [TAG_WIDTH-1:0] tag_q [BLOCK_NUM];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // NOTE: the tag storage is a memory and gets no reset; the valid bits alone
  // make stale contents harmless, and a reset would forbid RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache with single-cycle hits and a blocking
// IDLE/MISS refill FSM.
//   Sys_clk     sole clock, rising edge
//   Sys_rst_n   asynchronous active-low reset
//   Sys_rdy     global enable; low freezes all state and registered outputs
//   RoB_clear   pipeline flush; cancels any undelivered fetch
//   bus         icache_if.slave: fetch request/response, refill request/data,
//               performance counters
// Address split: offset = addr[1+BLOCK_WIDTH:2], index = next CACHE_WIDTH bits,
// tag = the rest; addr[1:0] is ignored. BLOCK_WIDTH must be at least 1.
// Optional feature: define ICACHE_PERF_CNT_EN to build the hit/miss counters;
// otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module icache #(
  parameter int BLOCK_WIDTH = icache_pkg::BLOCK_WIDTH,
  parameter int CACHE_WIDTH = icache_pkg::CACHE_WIDTH,
  parameter int ADDR_WIDTH  = icache_pkg::ADDR_WIDTH
) (
  input  logic     Sys_clk,
  input  logic     Sys_rst_n,
  input  logic     Sys_rdy,
  input  logic     RoB_clear,
  icache_if.slave  bus
);

  import icache_pkg::ic_state_e;
  import icache_pkg::IDLE;
  import icache_pkg::MISS;

  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int BLOCK_NUM  = 1 << CACHE_WIDTH;
  localparam int TAG_WIDTH  = icache_pkg::calc_tag_width(ADDR_WIDTH, CACHE_WIDTH, BLOCK_WIDTH);
  localparam int IDX_LSB    = 2 + BLOCK_WIDTH;
  localparam int TAG_LSB    = IDX_LSB + CACHE_WIDTH;

  // One block viewed as an array of instructions; element k is MCIC_block[32k+31:32k].
  typedef logic [BLOCK_SIZE-1:0][31:0] block_t;

  ic_state_e              state_q, state_d;
  logic                   cancel_q, cancel_d;
  logic [ADDR_WIDTH-1:2]  req_addr_q, req_addr_d;  // word address of the pending miss
  logic                   icif_en_q, icif_en_d;
  logic [31:0]            icif_inst_q, icif_inst_d;
  block_t                 data_q [BLOCK_NUM];

  block_t                 refill_block;
  logic [BLOCK_WIDTH-1:0] fetch_off, req_off;
  logic [CACHE_WIDTH-1:0] fetch_idx, req_idx;
  logic [TAG_WIDTH-1:0]   fetch_tag, req_tag;
  logic                   hit;
  logic                   refill_we;
  logic                   lookup_hit;
  logic                   lookup_miss;
  logic                   unused_byte_bits;

  assign fetch_off    = bus.IFIC_addr[IDX_LSB-1:2];
  assign fetch_idx    = bus.IFIC_addr[TAG_LSB-1:IDX_LSB];
  assign fetch_tag    = bus.IFIC_addr[ADDR_WIDTH-1:TAG_LSB];
  assign req_off      = req_addr_q[IDX_LSB-1:2];
  assign req_idx      = req_addr_q[TAG_LSB-1:IDX_LSB];
  assign req_tag      = req_addr_q[ADDR_WIDTH-1:TAG_LSB];
  assign refill_block = bus.MCIC_block;

  // Fetch addresses are word-aligned; the byte-select bits carry no information.
  assign unused_byte_bits = ^bus.IFIC_addr[1:0];

  icache_tag_array #(
    .CACHE_WIDTH (CACHE_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tag_array (
    .clk        (Sys_clk),
    .rst_n      (Sys_rst_n),
    .rd_index_i (fetch_idx),
    .rd_tag_i   (fetch_tag),
    .hit_o      (hit),
    .wr_en_i    (refill_we && Sys_rdy),
    .wr_index_i (req_idx),
    .wr_tag_i   (req_tag)
  );

  // Next-state and response logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    req_addr_d  = req_addr_q;
    icif_en_d   = 1'b0;
    icif_inst_d = icif_inst_q;
    refill_we   = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.IFIC_en) begin
          if (hit) begin
            lookup_hit = 1'b1;
            if (!RoB_clear) begin
              icif_en_d   = 1'b1;
              icif_inst_d = data_q[fetch_idx][fetch_off];
            end
          end else begin
            // A flush in the same cycle still lets the refill proceed, but the
            // request is already cancelled so it will never be delivered.
            lookup_miss = 1'b1;
            state_d     = MISS;
            req_addr_d  = bus.IFIC_addr[ADDR_WIDTH-1:2];
            cancel_d    = RoB_clear;
          end
        end
      end

      MISS: begin
        cancel_d = cancel_q | RoB_clear;
        if (bus.MCIC_en) begin
          refill_we = 1'b1;
          state_d   = IDLE;
          cancel_d  = 1'b0;
          if (!(cancel_q || RoB_clear)) begin
            icif_en_d   = 1'b1;
            icif_inst_d = refill_block[req_off];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_q     <= IDLE;
      cancel_q    <= 1'b0;
      req_addr_q  <= '0;
      icif_en_q   <= 1'b0;
      icif_inst_q <= '0;
    end else if (Sys_rdy) begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      req_addr_q  <= req_addr_d;
      icif_en_q   <= icif_en_d;
      icif_inst_q <= icif_inst_d;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rdy && refill_we) begin
      data_q[req_idx] <= refill_block;
    end
  end

  assign bus.ICIF_en   = icif_en_q;
  assign bus.ICIF_inst = icif_inst_q;
  // Dropping the request in the completion cycle keeps the controller from
  // seeing a still-pending miss and starting a second refill.
  assign bus.ICMC_en   = (state_q == MISS) && !bus.MCIC_en;
  assign bus.ICMC_addr = {req_addr_q[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (Sys_rdy) begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.ICIF_hit_cnt  = hit_cnt_q;
  assign bus.ICIF_miss_cnt = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf       = lookup_hit ^ lookup_miss;
  assign bus.ICIF_hit_cnt  = '0;
  assign bus.ICIF_miss_cnt = '0;
`endif

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter BLOCK_WIDTH, default 1, log2 of instructions per block.
REQ-002 SHALL have parameter CACHE_WIDTH, default 8, log2 of block count; direct-mapped.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have port Sys_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port Sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Sys_rdy  in  1  global enable; low freezes all state and outputs.
REQ-007 SHALL have port RoB_clear  in  1  pipeline flush; cancels any undelivered fetch.
REQ-008 SHALL have ports IFIC_en  in  1 and IFIC_addr  in  ADDR_WIDTH: fetch request, word-aligned PC.
REQ-009 SHALL have ports ICIF_en  out  1 (one-cycle pulse) and ICIF_inst  out  32: fetch response.
REQ-010 SHALL have ports ICMC_en  out  1 and ICMC_addr  out  ADDR_WIDTH: block refill request to the memory controller.
REQ-011 SHALL have ports MCIC_en  in  1 (one-cycle pulse) and MCIC_block  in  32*2^BLOCK_WIDTH: refill data.
REQ-012 SHALL have ports ICIF_hit_cnt, ICIF_miss_cnt  out  32 each: performance counters.

Function
REQ-013 Address split SHALL be: offset = addr[1+BLOCK_WIDTH:2], index = next CACHE_WIDTH bits, tag = remaining upper bits; addr[1:0] ignored.
REQ-014 Per-line storage SHALL be valid bit, tag, data block; MCIC_block[32k+31:32k] is instruction k, little-endian bytes.
REQ-015 States SHALL be IDLE and MISS.
REQ-016 IDLE, IFIC_en=1, hit: next edge ICIF_en=1, ICIF_inst=selected word; latency 1 cycle; stay IDLE.
REQ-017 IDLE, IFIC_en=1, miss: next edge enter MISS, latch request address, ICMC_addr = address with offset and addr[1:0] zeroed.
REQ-018 ICMC_en SHALL equal (state==MISS) AND NOT MCIC_en, combinationally, so the controller never re-issues a completed refill.
REQ-019 MISS, MCIC_en=1: at that edge write line (valid=1, tag, data), return to IDLE, pulse ICIF_en with the requested word unless cancelled (REQ-021).
REQ-020 IFIC_en SHALL be ignored while in MISS; fetch unit holds or re-issues after ICIF_en.
REQ-021 RoB_clear=1 in IDLE SHALL suppress ICIF_en for a request presented that cycle; in MISS it SHALL set a cancel flag: refill still completes and line is written, but ICIF_en is not pulsed; flag cleared on return to IDLE.
REQ-022 ICIF_en SHALL be 0 in every cycle not specified above; ICIF_inst holds last value.
REQ-023 MCIC_en arriving in IDLE SHALL be ignored.
REQ-024 Sys_rdy=0 SHALL hold state, lines, counters, ICIF_en/ICIF_inst; ICMC_en stays per REQ-018.

Reset
REQ-025 Sys_rst_n=0 SHALL immediately force: state IDLE, all valid bits 0, cancel flag 0, ICIF_en 0, ICIF_inst 0, ICMC_addr 0, counters 0; data/tag arrays need not reset.
REQ-026 Reset during MISS SHALL abandon the refill; a subsequent MCIC_en pulse is ignored per REQ-023.

Configuration
REQ-027 Macro ICACHE_PERF_CNT_EN defined: ICIF_hit_cnt increments on each hit lookup (REQ-016), ICIF_miss_cnt on each miss (REQ-017), wrapping at 2^32.
REQ-028 Macro ICACHE_PERF_CNT_EN undefined: both counter outputs tied to 0, no counter flops.

Structure
REQ-029 Shared package SHALL hold BLOCK_WIDTH, CACHE_WIDTH, ADDR_WIDTH, derived BLOCK_SIZE/BLOCK_NUM/TAG_WIDTH and the IDLE/MISS state encoding, shared with the memory controller.
REQ-030 One sub-module icache_tag_array (valid+tag storage, compare, hit output) SHALL be used; data array stays in icache.

Verification
REQ-031 After reset, fetch 0x0000_0000 -> ICMC_en=1, ICMC_addr=0x0; MCIC_block=0x00100093_00000013 -> next cycle ICIF_en=1, ICIF_inst=0x00000013.
REQ-032 Then fetch 0x0000_0004 -> ICIF_en=1 one cycle later, ICIF_inst=0x00100093, ICMC_en never asserts; hit_cnt=1, miss_cnt=1.
REQ-033 Fetch 0x0000_0800 (same index 0, new tag) -> miss, refill replaces line; refetch 0x0 -> miss again.
REQ-034 Miss on 0x100, RoB_clear pulsed mid-MISS, MCIC_en arrives -> no ICIF_en; refetch 0x100 -> hit in 1 cycle.
REQ-035 Sys_rst_n low for one cycle during MISS, then stray MCIC_en -> ignored, ICIF_en stays 0, fetch 0x0 misses.
